data_memory_ctrl: RTL
=====================

# data_memory_ctrl

Parametrised block-granular backing memory for the data side of the RV32IM pipeline, replacing the fixed 16-byte, fixed-delay main memory behind the data cache. Serves one read or one write of a whole block per request over the READ/WRITE/BUSYWAIT handshake the cache already drives. Adds a configurable cycle-accurate latency, per-byte write enables, captured request operands, and error flagging. Sits between the data cache miss/write-back path and the testbench memory image.

## Interface
- BLOCK_BYTES, 16: bytes per block; power of two, ≥4.
- ADDR_W, 28: block-address width.
- DEPTH, 32768: number of blocks stored; ≤ 2^ADDR_W.
- LATENCY, 5: BUSY cycles per access; ≥1.

- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  block read request; held until BUSYWAIT low.
- WRITE  in  1  block write request; held until BUSYWAIT low.
- ADDRESS  in  ADDR_W  block address.
- WRITEDATA  in  BLOCK_BYTES*8  write block; byte i = bits [8i+7:8i].
- BYTEEN  in  BLOCK_BYTES  per-byte write enable; bit i gates byte i.
- READDATA  out  BLOCK_BYTES*8  read block; reset 0.
- BUSYWAIT  out  1  stall to requester; reset value follows READ^WRITE (combinational).
- ERROR  out  1  sticky error flag; reset 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if READ^WRITE at edge → capture op, ADDRESS, WRITEDATA, BYTEEN; cnt ← LATENCY-1; → BUSY. Otherwise stay.
- BUSY: cnt decrements each edge; at edge with cnt==0 perform access, → DONE.
  - Read: READDATA ← stored block at captured address.
  - Write: for each i with BYTEEN[i]=1, byte i ← WRITEDATA byte i; other bytes unchanged. READDATA unchanged.
- DONE: one cycle; → IDLE unconditionally. A request still asserted in the following IDLE cycle is a new access.
- BUSYWAIT = (IDLE & (READ^WRITE)) | BUSY. Low in DONE.
- READ & WRITE both high in IDLE: not accepted; BUSYWAIT 0; ERROR ← 1 at that edge.
- Captured address ≥ DEPTH: write dropped; read returns all zeros; ERROR ← 1 at access edge; timing unchanged.
- Input changes during BUSY/DONE are ignored; captured values used.
- ERROR clears only on reset.
- RESET low (any time): state → IDLE, cnt → 0, READDATA → 0, ERROR → 0; an in-flight write is not committed. Storage contents are not cleared.

## Timing
- Request visible in cycle 0 (IDLE): BUSYWAIT high combinationally in cycle 0.
- Accept at edge 1; BUSY for cycles 1..LATENCY; access at edge LATENCY+1.
- Cycle LATENCY+1 (DONE): BUSYWAIT low, READDATA valid; requester deasserts at edge LATENCY+2.
- BUSYWAIT high for exactly LATENCY+1 cycles per accepted request; back-to-back requests spaced LATENCY+2 cycles.
- READDATA holds until the next read access or reset.

## Structure
- Shared header (data_memory_defs.vh): FSM state encodings, default parameter values, LATENCY counter width rule ($clog2(LATENCY)+1).
- One sub-module: data_memory_array — DEPTH × BLOCK_BYTES*8 storage, synchronous byte-enabled write, synchronous read, no reset on contents.
- Controller holds FSM, latency counter, operand capture registers, range check and ERROR.

## Test plan
- Reset then read block 0x10, LATENCY=5 → BUSYWAIT high 6 cycles, READDATA=0 in DONE, ERROR=0.
- Write 0x0123…CDEF (full BYTEEN=0xFFFF) to block 0x3, then read 0x3 → READDATA equals written value; BUSYWAIT low exactly in cycle 6 of each access.
- Preload block 0x7 with 0xAA… ; write 0x55… with BYTEEN=0x00F0 → read returns bytes 4–7 = 0x55, all others 0xAA.
- READ and WRITE both high in IDLE → BUSYWAIT 0, ERROR=1 next cycle, storage unchanged; ADDRESS=DEPTH read → READDATA=0, ERROR=1.
- Write to block 0x9 with RESET pulsed low in BUSY cycle 3 → FSM IDLE, READDATA=0, ERROR=0; subsequent read of 0x9 returns prior contents.
- Change ADDRESS/WRITEDATA mid-BUSY → write lands at captured address with captured data only.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the data-side block memory: default geometry,
// controller state encoding and the latency counter width rule.
package data_memory_ctrl_pkg;

    localparam int DEF_BLOCK_BYTES = 16;
    localparam int DEF_ADDR_W      = 28;
    localparam int DEF_DEPTH       = 32768;
    localparam int DEF_LATENCY     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Counter must hold LATENCY-1; one spare bit keeps LATENCY=1 legal.
    function automatic int latency_cnt_w(input int latency);
        return $clog2(latency) + 1;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Block storage: DEPTH blocks of BLOCK_BYTES bytes, byte-enabled synchronous
// write, synchronous read into an output register. Contents are never reset;
// only the read register is.
module data_memory_array #(
    parameter int BLOCK_BYTES = 16,
    parameter int DEPTH       = 32768,
    parameter int IDX_W       = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     wr_en,
    input  logic [BLOCK_BYTES-1:0]   wr_be,
    input  logic [BLOCK_BYTES*8-1:0] wr_data,
    input  logic                     rd_en,
    input  logic                     rd_zero,
    input  logic [IDX_W-1:0]         addr,
    output logic [BLOCK_BYTES*8-1:0] rd_data
);

    logic [BLOCK_BYTES*8-1:0] mem [DEPTH];

    // Byte-granular write; disabled bytes keep their old contents.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Read register: updated only on a read access, zeros for out-of-range.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Block-granular backing memory controller for the data cache. Captures one
// read or write request, waits LATENCY busy cycles, performs the access, then
// spends one DONE cycle with BUSYWAIT low before accepting the next request.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [ADDR_W-1:0]        ADDRESS,
    input  logic [BLOCK_BYTES*8-1:0] WRITEDATA,
    input  logic [BLOCK_BYTES-1:0]   BYTEEN,
    output logic [BLOCK_BYTES*8-1:0] READDATA,
    output logic                     BUSYWAIT,
    output logic                     ERROR
);

    localparam int CNT_W = latency_cnt_w(LATENCY);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    mem_state_t               state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     cap_write_reg;
    logic [ADDR_W-1:0]        cap_addr_reg;
    logic [BLOCK_BYTES*8-1:0] cap_data_reg;
    logic [BLOCK_BYTES-1:0]   cap_be_reg;
    logic                     error_reg;

    logic in_range;
    logic access_now;
    logic wr_en;
    logic rd_en;

    assign in_range   = ({1'b0, cap_addr_reg} < DEPTH_L);
    assign access_now = (state_reg == ST_BUSY) && (cnt_reg == '0);
    assign wr_en      = access_now && cap_write_reg && in_range;
    assign rd_en      = access_now && !cap_write_reg;

    // Stall while a lone request waits in IDLE or an access is in flight.
    assign BUSYWAIT = ((state_reg == ST_IDLE) && (READ ^ WRITE)) || (state_reg == ST_BUSY);
    assign ERROR    = error_reg;

    // Request FSM: capture operands, count down latency, flag errors.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            cap_write_reg <= 1'b0;
            cap_addr_reg  <= '0;
            cap_data_reg  <= '0;
            cap_be_reg    <= '0;
            error_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (READ ^ WRITE) begin
                        cap_write_reg <= WRITE;
                        cap_addr_reg  <= ADDRESS;
                        cap_data_reg  <= WRITEDATA;
                        cap_be_reg    <= BYTEEN;
                        cnt_reg       <= CNT_W'(LATENCY - 1);
                        state_reg     <= ST_BUSY;
                    end else if (READ && WRITE) begin
                        error_reg <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_DONE;
                        if (!in_range) begin
                            error_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    data_memory_array #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .DEPTH       (DEPTH),
        .IDX_W       (IDX_W)
    ) u_array (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (wr_en),
        .wr_be   (cap_be_reg),
        .wr_data (cap_data_reg),
        .rd_en   (rd_en),
        .rd_zero (!in_range),
        .addr    (cap_addr_reg[IDX_W-1:0]),
        .rd_data (READDATA)
    );

endmodule
